// File: rtl/ysyx_22040237_mdu_pkg.sv
// Shared decode constants and state encoding for the RV64M multiply/divide unit.
package ysyx_22040237_mdu_pkg;

  localparam logic [2:0] EXU_INFO_MDU = 3'd4;

  localparam int EXU_INFO_MDU_WOP    = 3;
  localparam int EXU_INFO_MDU_MUL    = 4;
  localparam int EXU_INFO_MDU_MULH   = 5;
  localparam int EXU_INFO_MDU_MULHSU = 6;
  localparam int EXU_INFO_MDU_MULHU  = 7;
  localparam int EXU_INFO_MDU_DIV    = 8;
  localparam int EXU_INFO_MDU_DIVU   = 9;
  localparam int EXU_INFO_MDU_REM    = 10;
  localparam int EXU_INFO_MDU_REMU   = 11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040237_mdu_div.sv
// Radix-2 restoring divider on operand magnitudes; quotient/remainder signs applied on the outputs.
module ysyx_22040237_mdu_div
  import ysyx_22040237_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            signed_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0]  quot_q, rem_q, dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             word_q, q_neg_q, r_neg_q;

  logic             dvd_neg, dsr_neg;
  logic [XLEN-1:0]  dvd_mag, dsr_mag, dvd_align;
  logic [XLEN:0]    rem_shift, diff;
  logic             ge;
  logic [XLEN-1:0]  q_fix, r_fix;

  assign dvd_neg   = signed_i & dividend_i[XLEN-1];
  assign dsr_neg   = signed_i & divisor_i[XLEN-1];
  assign dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
  assign dsr_mag   = dsr_neg ? -divisor_i : divisor_i;
  // Word dividends are left-aligned so the same MSB-first shift serves both widths.
  assign dvd_align = word_i ? {dvd_mag[XLEN/2-1:0], {(XLEN/2){1'b0}}} : dvd_mag;

  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dsr_q};
  assign ge        = ~diff[XLEN];

  assign done_o = step_i & (cnt_q == (word_q ? CNT_W'(XLEN/2-1) : CNT_W'(XLEN-1)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q  <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      word_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (start_i) begin
      quot_q  <= dvd_align;
      rem_q   <= '0;
      dsr_q   <= dsr_mag;
      cnt_q   <= '0;
      word_q  <= word_i;
      q_neg_q <= dvd_neg ^ dsr_neg;
      r_neg_q <= dvd_neg;
    end else if (step_i) begin
      rem_q  <= ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quot_q <= {quot_q[XLEN-2:0], ge};
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign q_fix  = q_neg_q ? -quot_q : quot_q;
  assign r_fix  = r_neg_q ? -rem_q : rem_q;
  assign quot_o = word_q ? sext32(q_fix[31:0]) : q_fix;
  assign rem_o  = word_q ? sext32(r_fix[31:0]) : r_fix;

endmodule

// File: rtl/ysyx_22040237_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and FSM here, divider in a sub-module.
module ysyx_22040237_mdu
  import ysyx_22040237_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [15:0]     exu_info_bus_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_idx_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_idx_o,
  output logic            busy_o
);

  mdu_state_e state_q, state_d;

  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q, result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        rd_q;
  logic              wop_q, div_q, rem_sel_q, mul_lo_q, mul_neg_q;

  logic in_wop, op_mul, op_mulh, op_mulhsu, op_div, op_divu, op_rem, op_remu;
  logic in_div, div_signed, a_sext, b_sext, accept, special, div_zero, div_ovf, calc_last;
  logic [XLEN-1:0] a_ext, b_ext, a_res, a_mag, b_mag, special_res, div_quot, div_rem;
  logic [XLEN-1:0] mul_res, fix_res;
  logic [2*XLEN-1:0] mul_full;
  logic a_neg, b_neg, div_done, unused_bits;

  assign unused_bits = ^exu_info_bus_i[15:12];

  assign in_wop    = exu_info_bus_i[EXU_INFO_MDU_WOP];
  assign op_mul    = exu_info_bus_i[EXU_INFO_MDU_MUL];
  assign op_mulh   = exu_info_bus_i[EXU_INFO_MDU_MULH];
  assign op_mulhsu = exu_info_bus_i[EXU_INFO_MDU_MULHSU];
  assign op_div    = exu_info_bus_i[EXU_INFO_MDU_DIV];
  assign op_divu   = exu_info_bus_i[EXU_INFO_MDU_DIVU];
  assign op_rem    = exu_info_bus_i[EXU_INFO_MDU_REM];
  assign op_remu   = exu_info_bus_i[EXU_INFO_MDU_REMU];

  assign in_div     = op_div | op_divu | op_rem | op_remu;
  assign div_signed = op_div | op_rem;
  assign a_sext     = op_mulh | op_mulhsu | div_signed;
  assign b_sext     = op_mulh | div_signed;

  assign a_ext = in_wop ? (a_sext ? sext32(op1_i[31:0]) : {32'b0, op1_i[31:0]}) : op1_i;
  assign b_ext = in_wop ? (b_sext ? sext32(op2_i[31:0]) : {32'b0, op2_i[31:0]}) : op2_i;
  assign a_res = in_wop ? sext32(op1_i[31:0]) : op1_i;

  assign a_neg = (op_mulh | op_mulhsu) & a_ext[XLEN-1];
  assign b_neg = op_mulh & b_ext[XLEN-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  assign div_zero = in_div & (b_ext == '0);
  assign div_ovf  = div_signed & (&b_ext) &
                    (in_wop ? (op1_i[31:0] == 32'h8000_0000) : (op1_i == {1'b1, {(XLEN-1){1'b0}}}));
  assign special  = div_zero | div_ovf;
  assign special_res = div_zero ? ((op_div | op_divu) ? '1 : a_res)
                                : (op_div ? a_res : '0);

  assign accept = (state_q == MDU_IDLE) & in_valid_i & ~flush_i &
                  (exu_info_bus_i[2:0] == EXU_INFO_MDU) & (|exu_info_bus_i[11:4]);

  assign calc_last = div_q ? div_done
                           : (cnt_q == (wop_q ? CNT_W'(XLEN/2-1) : CNT_W'(XLEN-1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = MDU_IDLE;
    end else begin
      unique case (state_q)
        MDU_IDLE: if (accept)      state_d = special ? MDU_DONE : MDU_CALC;
        MDU_CALC: if (calc_last)   state_d = MDU_FIX;
        MDU_FIX:                   state_d = MDU_DONE;
        MDU_DONE: if (out_ready_i) state_d = MDU_IDLE;
        default:                   state_d = MDU_IDLE;
      endcase
    end
  end

  assign mul_full = mul_neg_q ? -acc_q : acc_q;
  assign mul_res  = mul_lo_q ? (wop_q ? sext32(mul_full[31:0]) : mul_full[XLEN-1:0])
                             : mul_full[2*XLEN-1:XLEN];
  assign fix_res  = div_q ? (rem_sel_q ? div_rem : div_quot) : mul_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      wop_q     <= 1'b0;
      div_q     <= 1'b0;
      rem_sel_q <= 1'b0;
      mul_lo_q  <= 1'b0;
      mul_neg_q <= 1'b0;
    end else if (accept) begin
      acc_q     <= '0;
      mcand_q   <= {{XLEN{1'b0}}, a_mag};
      mplier_q  <= b_mag;
      cnt_q     <= '0;
      rd_q      <= rd_idx_i;
      wop_q     <= in_wop;
      div_q     <= in_div;
      rem_sel_q <= op_rem | op_remu;
      mul_lo_q  <= op_mul;
      mul_neg_q <= a_neg ^ b_neg;
      if (special) result_q <= special_res;
    end else if (state_q == MDU_CALC) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end else if (state_q == MDU_FIX) begin
      result_q <= fix_res;
    end
  end

  ysyx_22040237_mdu_div #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (accept & in_div & ~special),
    .step_i     ((state_q == MDU_CALC) & div_q),
    .signed_i   (div_signed),
    .word_i     (in_wop),
    .dividend_i (a_ext),
    .divisor_i  (b_ext),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  assign in_ready_o  = (state_q == MDU_IDLE);
  assign out_valid_o = (state_q == MDU_DONE);
  assign busy_o      = (state_q != MDU_IDLE);
  assign result_o    = result_q;
  assign rd_idx_o    = rd_q;

endmodule

// File: tb/tb_ysyx_22040237_mdu.sv
// Self-checking bench: directed corner cases plus random ops against an arithmetic reference model.
module tb_ysyx_22040237_mdu;
  import ysyx_22040237_mdu_pkg::*;

  localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
  localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] info;
  logic [63:0] op1, op2, result;
  logic [4:0]  rd, rd_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ysyx_22040237_mdu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .exu_info_bus_i (info),
    .op1_i          (op1),
    .op2_i          (op2),
    .rd_idx_i       (rd),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result),
    .rd_idx_o       (rd_out),
    .busy_o         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] mk_info(input int op, input bit w);
    logic [15:0] v;
    v       = '0;
    v[2:0]  = EXU_INFO_MDU;
    v[3]    = w;
    v[4+op] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V M semantics from plain 128-bit products and native division.
  function automatic logic [63:0] ref_result(input int op, input bit w,
                                              input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    longint       x, y;
    int           xw, yw;
    logic [31:0]  r32;
    logic [63:0]  r64;
    case (op)
      OP_MUL: begin
        r64 = a * b;
        return w ? sx(r64[31:0]) : r64;
      end
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        ea = (op == OP_MULHU) ? {64'b0, a} : {{64{a[63]}}, a};
        eb = (op == OP_MULH)  ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ea * eb;
        return p[127:64];
      end
      default: ;
    endcase
    if (w) begin
      xw = a[31:0];
      yw = b[31:0];
      case (op)
        OP_DIV:  r32 = (yw == 0) ? 32'hFFFF_FFFF :
                       (a[31:0] == 32'h8000_0000 && yw == -1) ? a[31:0] : 32'(xw / yw);
        OP_REM:  r32 = (yw == 0) ? a[31:0] :
                       (a[31:0] == 32'h8000_0000 && yw == -1) ? 32'h0 : 32'(xw % yw);
        OP_DIVU: r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
        default: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
      endcase
      return sx(r32);
    end
    x = a;
    y = b;
    case (op)
      OP_DIV:  r64 = (b == 0) ? ALL1 : (a == MIN64 && b == ALL1) ? a : 64'(x / y);
      OP_REM:  r64 = (b == 0) ? a : (a == MIN64 && b == ALL1) ? 64'h0 : 64'(x % y);
      OP_DIVU: r64 = (b == 0) ? ALL1 : a / b;
      default: r64 = (b == 0) ? a : a % b;
    endcase
    return r64;
  endfunction

  function automatic bit is_special(input int op, input bit w,
                                    input logic [63:0] a, input logic [63:0] b);
    bit dz, ov;
    if (op < OP_DIV) return 1'b0;
    dz = w ? (b[31:0] == 0) : (b == 0);
    ov = (op == OP_DIV || op == OP_REM) &&
         (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == ALL1));
    return dz | ov;
  endfunction

  // Drives one request; returns after the accept edge (+1).
  task automatic issue(input int op, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] r);
    info     = mk_info(op, w);
    op1      = a;
    op2      = b;
    rd       = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency is counted in edges after the accept edge; special cases are valid right after it.
  task automatic run_op(input string tag, input int op, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] r);
    logic [63:0] exp;
    int lat, exp_lat;
    exp     = ref_result(op, w, a, b);
    exp_lat = is_special(op, w, a, b) ? 0 : (w ? 33 : 65);
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    issue(op, w, a, b, r);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, result, exp);
    check({tag, "/rd"}, 64'(rd_out), 64'(r));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/consumed"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return ALL1;
      2: return MIN64;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int cnt, op;
    bit w;
    logic [63:0] exp, a, b;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    info = '0; op1 = '0; op2 = '0; rd = '0;
    #1;
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/result", result, 64'd0);
    check("reset/rd", 64'(rd_out), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset/in_ready", 64'(in_ready), 64'd1);

    // Requests that must be ignored.
    info = mk_info(OP_MUL, 1'b0); info[2:0] = 3'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("ignore/type", 64'(busy), 64'd0);
    info = '0; info[2:0] = EXU_INFO_MDU;
    @(posedge clk); #1;
    check("ignore/noop", 64'(busy), 64'd0);
    info = mk_info(OP_MUL, 1'b0); flush = 1'b1;
    @(posedge clk); #1;
    check("ignore/flush", 64'(busy), 64'd0);
    flush = 1'b0; in_valid = 1'b0;

    run_op("mul",     OP_MUL,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9);
    check("mul/value", result, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mulhu",   OP_MULHU,  0, ALL1, ALL1, 5'd3);
    check("mulhu/value", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu",  OP_MULHSU, 0, ALL1, 64'd2, 5'd4);
    check("mulhsu/value", result, ALL1);
    run_op("div0",    OP_DIV,    0, 64'd5, 64'd0, 5'd5);
    check("div0/value", result, ALL1);
    run_op("remu0",   OP_REMU,   0, 64'd5, 64'd0, 5'd6);
    check("remu0/value", result, 64'd5);
    run_op("divovf",  OP_DIV,    0, MIN64, ALL1, 5'd7);
    check("divovf/value", result, MIN64);
    run_op("removf",  OP_REM,    0, MIN64, ALL1, 5'd8);
    check("removf/value", result, 64'd0);
    run_op("divw",    OP_DIV,    1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd10);
    check("divw/value", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("remw",    OP_REM,    1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd11);
    check("remw/value", result, ALL1);

    // Backpressure: result held while the consumer stalls.
    exp = ref_result(OP_MULH, 0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
    issue(OP_MULH, 0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 5'd21);
    cnt = 0;
    while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("bp/latency", 64'(cnt), 64'd65);
    for (int i = 0; i < 10; i++) begin
      check("bp/result", result, exp);
      check("bp/rd", 64'(rd_out), 64'd21);
      check("bp/in_ready", 64'(in_ready), 64'd0);
      check("bp/out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp/in_ready_after", 64'(in_ready), 64'd1);

    // Flush at CALC iteration 20.
    issue(OP_DIVU, 0, 64'd1000, 64'd7, 5'd12);
    repeat (19) @(posedge clk);
    #1;
    check("flush/busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/busy", 64'(busy), 64'd0);
    check("flush/in_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    check("flush/no_valid", 64'(cnt), 64'd0);

    // Asynchronous reset mid-CALC.
    issue(OP_MUL, 0, 64'd3, 64'd5, 5'd17);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/result", result, 64'd0);
    check("rst/rd", 64'(rd_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst/in_ready", 64'(in_ready), 64'd1);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 1);
      if (w) begin
        op = $urandom_range(0, 4);
        op = (op == 0) ? OP_MUL : OP_DIV + op - 1;
      end else begin
        op = $urandom_range(0, 7);
      end
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d_op%0d_w%0d", i, op, w), op, w, a, b, 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
